// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory port arbiter.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin winner selection).
package mem_arb_pkg;

    localparam int DEF_BITSIZE = 32;
    localparam int DEF_DATA_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_IF,
        SERVE_LSU
    } arb_state_t;

    typedef enum logic {
        GNT_IF,
        GNT_LSU
    } grant_t;

    function automatic arb_state_t serve_state(input grant_t g);
        return (g == GNT_LSU) ? SERVE_LSU : SERVE_IF;
    endfunction

endpackage

// File: rtl/arb_select.sv
// Combinational winner selection between fetch and load/store requests.
// MEM_ARB_ROUND_ROBIN_EN adds the last-served input and alternating tie-break.
module arb_select
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   lsu_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  grant_t last,
`endif
    output grant_t grant,
    output logic   any_req
);

    logic tie_lsu;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On a tie the side that was not served last goes first.
    assign tie_lsu = (last == GNT_IF);
`else
    assign tie_lsu = 1'b1;
`endif

    always_comb begin
        any_req = if_req | lsu_req;
        grant   = GNT_IF;
        if (lsu_req && !if_req) begin
            grant = GNT_LSU;
        end else if (lsu_req && if_req) begin
            grant = tie_lsu ? GNT_LSU : GNT_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and LSU.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin instead of LSU>IF).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BITSIZE = DEF_BITSIZE,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic               clk,
    input  logic               reset_i,
    input  logic [BITSIZE-1:0] if_addr_i,
    input  logic               if_read_i,
    output logic [DATA_W-1:0]  if_data_o,
    output logic               if_valid_o,
    input  logic [BITSIZE-1:0] lsu_addr_i,
    input  logic               lsu_read_i,
    input  logic               lsu_write_i,
    input  logic [DATA_W-1:0]  lsu_wdata_i,
    output logic [DATA_W-1:0]  lsu_data_o,
    output logic               lsu_valid_o,
    output logic [BITSIZE-1:0] mem_addr_o,
    output logic [DATA_W-1:0]  mem_wdata_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    input  logic [DATA_W-1:0]  mem_data_i,
    input  logic               mem_valid_i
);

    arb_state_t         state;
    grant_t             grant_q;
    grant_t             gnt;
    logic               any_req;
    logic               lsu_req;
    logic               done;
    logic [BITSIZE-1:0] addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               is_write_q;

    assign lsu_req = lsu_read_i | lsu_write_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    grant_t last_q;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            last_q <= GNT_IF;
        end else if (state == IDLE && any_req) begin
            last_q <= gnt;
        end
    end
`endif

    arb_select u_sel (
        .if_req  (if_read_i),
        .lsu_req (lsu_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last    (last_q),
`endif
        .grant   (gnt),
        .any_req (any_req)
    );

    assign done = (state != IDLE) && mem_valid_i;

    // Requests are sampled only in IDLE; the latched copy drives memory.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state      <= IDLE;
            grant_q    <= GNT_IF;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state   <= serve_state(gnt);
                        grant_q <= gnt;
                        if (gnt == GNT_LSU) begin
                            addr_q     <= lsu_addr_i;
                            wdata_q    <= lsu_wdata_i;
                            is_write_q <= lsu_write_i;
                        end else begin
                            addr_q     <= if_addr_i;
                            wdata_q    <= '0;
                            is_write_q <= 1'b0;
                        end
                    end
                end
                SERVE_IF, SERVE_LSU: begin
                    if (mem_valid_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_read_o  = (state == SERVE_IF)
                       | ((state == SERVE_LSU) & ~is_write_q);
    assign mem_write_o = (state == SERVE_LSU) & is_write_q;

    assign if_valid_o  = done && (grant_q == GNT_IF);
    assign lsu_valid_o = done && (grant_q == GNT_LSU);
    assign if_data_o   = if_valid_o  ? mem_data_i : '0;
    assign lsu_data_o  = lsu_valid_o ? mem_data_i : '0;

`ifndef SYNTHESIS
    // Both LSU strobes together are served as a store.
    illegal_rw: assert property (
        @(posedge clk) disable iff (reset_i)
        !(lsu_read_i && lsu_write_i)
    ) else $warning("lsu_read_i and lsu_write_i both set, served as store");
`endif

endmodule
